// File: rtl/pc_next_unit_pkg.sv
// Shared definitions for the next-PC unit: redirect mode codes and FSM state encoding.
package pc_next_pkg;
   localparam logic [1:0] MODE_NONE = 2'b00;
   localparam logic [1:0] MODE_BR   = 2'b01;
   localparam logic [1:0] MODE_J    = 2'b10;
   localparam logic [1:0] MODE_JR   = 2'b11;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;
endpackage

// File: rtl/pc_next_unit_if.sv
// Redirect/fetch bus between hazard/branch resolution (master) and the next-PC unit (slave).
interface pc_next_unit_if #(
   parameter int ADDR_W = 32,
   parameter int IDX_W  = 26,
   parameter int IMM_W  = 16
);
   logic              stall_i;
   logic              redir_valid_i;
   logic              redir_ready_o;
   logic [1:0]        redir_mode_i;
   logic [ADDR_W-1:0] redir_base_i;
   logic [IMM_W-1:0]  redir_imm_i;
   logic [IDX_W-1:0]  redir_idx_i;
   logic [ADDR_W-1:0] redir_reg_i;
   logic [ADDR_W-1:0] pc_o;
   logic [ADDR_W-1:0] pc_plus_o;
   logic              redir_taken_o;
   logic              misalign_o;

   modport master (
      output stall_i, redir_valid_i, redir_mode_i, redir_base_i, redir_imm_i, redir_idx_i, redir_reg_i,
      input  redir_ready_o, pc_o, pc_plus_o, redir_taken_o, misalign_o
   );

   modport slave (
      input  stall_i, redir_valid_i, redir_mode_i, redir_base_i, redir_imm_i, redir_idx_i, redir_reg_i,
      output redir_ready_o, pc_o, pc_plus_o, redir_taken_o, misalign_o
   );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational redirect target formation (branch / jump / register).
// PC_ALIGN_CHK_EN: force register targets onto an instruction boundary and flag it.
module pc_target_calc
   import pc_next_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int IDX_W     = 26,
   parameter int IMM_W     = 16,
   parameter int STEP_LOG2 = 2
) (
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] base,
   input  logic [IMM_W-1:0]  imm,
   input  logic [IDX_W-1:0]  idx,
   input  logic [ADDR_W-1:0] reg_tgt,
   output logic [ADDR_W-1:0] target,
   output logic              misalign
);
   generate
      if (ADDR_W < IDX_W + STEP_LOG2) begin : g_bad_width
         $fatal(1, "pc_target_calc: ADDR_W must be >= IDX_W+STEP_LOG2");
      end
   endgenerate

   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(1) << STEP_LOG2;
   // Bits supplied by the jump index (plus the zero low bits); everything above comes from seq.
   localparam logic [ADDR_W-1:0] IDX_MASK = {ADDR_W{1'b1}} >> (ADDR_W - IDX_W - STEP_LOG2);

   logic [ADDR_W-1:0] seq, br_tgt, j_tgt, jr_tgt;

   assign seq    = base + STEP;
   assign br_tgt = seq + (ADDR_W'($signed(imm)) << STEP_LOG2);
   assign j_tgt  = (seq & ~IDX_MASK) | (ADDR_W'(idx) << STEP_LOG2);

`ifdef PC_ALIGN_CHK_EN
   localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << STEP_LOG2;
   assign jr_tgt   = reg_tgt & ALIGN_MASK;
   assign misalign = (mode == MODE_JR) && (|(reg_tgt & ~ALIGN_MASK));
`else
   assign jr_tgt   = reg_tgt;
   assign misalign = 1'b0;
`endif

   always_comb begin
      target = seq;
      case (mode)
         MODE_BR: target = br_tgt;
         MODE_J:  target = j_tgt;
         MODE_JR: target = jr_tgt;
         default: target = seq;
      endcase
   end
endmodule

// File: rtl/pc_next_unit.sv
// Fetch PC register with redirect handling; a redirect accepted during a stall is parked
// in a pending buffer (HOLD) and applied when the stall releases. Honours PC_ALIGN_CHK_EN.
module pc_next_unit
   import pc_next_pkg::*;
#(
   parameter int              ADDR_W    = 32,
   parameter int              IDX_W     = 26,
   parameter int              IMM_W     = 16,
   parameter int              STEP_LOG2 = 2,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input logic           clk_i,
   input logic           rst_i,
   pc_next_unit_if.slave bus
);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(1) << STEP_LOG2;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pending, target;
   logic              pend_mis, calc_mis, taken, mis;
   logic              ready, redirect;

   pc_target_calc #(
      .ADDR_W(ADDR_W), .IDX_W(IDX_W), .IMM_W(IMM_W), .STEP_LOG2(STEP_LOG2)
   ) u_calc (
      .mode    (bus.redir_mode_i),
      .base    (bus.redir_base_i),
      .imm     (bus.redir_imm_i),
      .idx     (bus.redir_idx_i),
      .reg_tgt (bus.redir_reg_i),
      .target  (target),
      .misalign(calc_mis)
   );

   assign redirect = bus.redir_valid_i && ready && (bus.redir_mode_i != MODE_NONE);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= ST_RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:  if (redirect && bus.stall_i) state_nxt = ST_HOLD;
         ST_HOLD: if (!bus.stall_i)            state_nxt = ST_RUN;
         default: state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      ready = (state == ST_RUN);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pc       <= RESET_PC;
         pending  <= '0;
         pend_mis <= 1'b0;
         taken    <= 1'b0;
         mis      <= 1'b0;
      end else begin
         taken <= 1'b0;
         mis   <= 1'b0;
         if (state == ST_HOLD) begin
            if (!bus.stall_i) begin
               pc    <= pending;
               taken <= 1'b1;
               mis   <= pend_mis;
            end
         end else if (redirect && bus.stall_i) begin
            pending  <= target;
            pend_mis <= calc_mis;
         end else if (redirect) begin
            pc    <= target;
            taken <= 1'b1;
            mis   <= calc_mis;
         end else if (!bus.stall_i) begin
            pc <= pc + STEP;
         end
      end
   end

   assign bus.redir_ready_o = ready;
   assign bus.pc_o          = pc;
   assign bus.pc_plus_o     = pc + STEP;
   assign bus.redir_taken_o = taken;
   assign bus.misalign_o    = mis;
endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: default instance plus an IDX_W=30 instance for jump width.
module tb_pc_next_unit;
   import pc_next_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic        mis;
      logic        ready;
   } exp_t;
   exp_t sb[$];

   pc_next_unit_if #(.ADDR_W(32), .IDX_W(26), .IMM_W(16)) bus ();
   pc_next_unit_if #(.ADDR_W(32), .IDX_W(30), .IMM_W(16)) bus_b ();

   pc_next_unit #(.ADDR_W(32), .IDX_W(26), .IMM_W(16), .STEP_LOG2(2), .RESET_PC(32'h0))
      dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));
   pc_next_unit #(.ADDR_W(32), .IDX_W(30), .IMM_W(16), .STEP_LOG2(2), .RESET_PC(32'h0))
      dut_b (.clk_i(clk), .rst_i(rst_n), .bus(bus_b));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue the expected post-edge state, then compare.
   task automatic step(input string tag, input logic stall, input logic valid, input logic [1:0] mode,
                       input logic [31:0] base, input logic [15:0] imm, input logic [25:0] idx,
                       input logic [31:0] rg, input logic [31:0] epc, input logic et, input logic em,
                       input logic er);
      exp_t e;
      bus.stall_i       = stall;
      bus.redir_valid_i = valid;
      bus.redir_mode_i  = mode;
      bus.redir_base_i  = base;
      bus.redir_imm_i   = imm;
      bus.redir_idx_i   = idx;
      bus.redir_reg_i   = rg;
      sb.push_back('{pc: epc, taken: et, mis: em, ready: er});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".pc"},    bus.pc_o,                  e.pc);
      chk({tag, ".taken"}, {31'b0, bus.redir_taken_o}, {31'b0, e.taken});
      chk({tag, ".mis"},   {31'b0, bus.misalign_o},    {31'b0, e.mis});
      chk({tag, ".ready"}, {31'b0, bus.redir_ready_o}, {31'b0, e.ready});
   endtask

   task automatic idle(input string tag, input logic [31:0] epc);
      step(tag, 1'b0, 1'b0, MODE_NONE, 32'h0, 16'h0, 26'h0, 32'h0, epc, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      bus.stall_i = 0; bus.redir_valid_i = 0; bus.redir_mode_i = MODE_NONE;
      bus.redir_base_i = 0; bus.redir_imm_i = 0; bus.redir_idx_i = 0; bus.redir_reg_i = 0;
      bus_b.stall_i = 0; bus_b.redir_valid_i = 0; bus_b.redir_mode_i = MODE_NONE;
      bus_b.redir_base_i = 0; bus_b.redir_imm_i = 0; bus_b.redir_idx_i = 0; bus_b.redir_reg_i = 0;

      #12;
      chk("rst.pc",    bus.pc_o, 32'h0);
      chk("rst.taken", {31'b0, bus.redir_taken_o}, 32'h0);
      chk("rst.mis",   {31'b0, bus.misalign_o}, 32'h0);
      chk("rst.ready", {31'b0, bus.redir_ready_o}, 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rel.pc", bus.pc_o, 32'h0);

      idle("seq1", 32'h4);
      idle("seq2", 32'h8);
      idle("seq3", 32'hC);

      step("br", 0, 1, MODE_BR, 32'h100, 16'hFFFE, 26'h0, 32'h0, 32'hFC, 1, 0, 1);
      idle("br_after", 32'h100);

      bus_b.redir_valid_i = 1; bus_b.redir_mode_i = MODE_J;
      bus_b.redir_base_i  = 32'h3000_0000; bus_b.redir_idx_i = 30'h10;
      step("j", 0, 1, MODE_J, 32'h3000_0000, 16'h0, 26'h10, 32'h0, 32'h3000_0040, 1, 0, 1);
      chk("j_idx30.pc", bus_b.pc_o, 32'h40);
      bus_b.redir_valid_i = 0; bus_b.redir_mode_i = MODE_NONE;
      idle("j_after", 32'h3000_0044);

      step("hold0", 1, 1, MODE_J, 32'h0, 16'h0, 26'h40, 32'h0, 32'h3000_0044, 0, 0, 0);
      step("hold1", 1, 1, MODE_J, 32'h0, 16'h0, 26'h40, 32'h0, 32'h3000_0044, 0, 0, 0);
      step("hold2", 1, 1, MODE_J, 32'h0, 16'h0, 26'h40, 32'h0, 32'h3000_0044, 0, 0, 0);
      step("hold3", 1, 1, MODE_J, 32'h0, 16'h0, 26'h40, 32'h0, 32'h3000_0044, 0, 0, 0);
      step("unhold", 0, 0, MODE_NONE, 32'h0, 16'h0, 26'h0, 32'h0, 32'h100, 1, 0, 1);
      idle("unhold_after", 32'h104);

      step("hold_rst", 1, 1, MODE_J, 32'h0, 16'h0, 26'h40, 32'h0, 32'h104, 0, 0, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("hold_rst.pc",    bus.pc_o, 32'h0);
      chk("hold_rst.ready", {31'b0, bus.redir_ready_o}, 32'h1);
      bus.stall_i = 0; bus.redir_valid_i = 0;
      #1 rst_n = 1'b1;
      idle("hold_rst_after", 32'h4);

      step("wrap_set", 0, 1, MODE_JR, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 1);
      chk("wrap_set.plus", bus.pc_plus_o, 32'h0);
      idle("wrap", 32'h0);
      chk("wrap.plus", bus.pc_plus_o, 32'h4);

`ifdef PC_ALIGN_CHK_EN
      step("jr_mis", 0, 1, MODE_JR, 32'h0, 16'h0, 26'h0, 32'h1003, 32'h1000, 1, 1, 1);
      idle("jr_mis_after", 32'h1004);
`else
      step("jr_mis", 0, 1, MODE_JR, 32'h0, 16'h0, 26'h0, 32'h1003, 32'h1003, 1, 0, 1);
      idle("jr_mis_after", 32'h1007);
`endif

      step("b2b0", 0, 1, MODE_JR, 32'h0, 16'h0, 26'h0, 32'h2000, 32'h2000, 1, 0, 1);
      step("b2b1", 0, 1, MODE_JR, 32'h0, 16'h0, 26'h0, 32'h3000, 32'h3000, 1, 0, 1);
      step("none", 0, 1, MODE_NONE, 32'h0, 16'h0, 26'h0, 32'h8000, 32'h3004, 0, 0, 1);
      step("stall", 1, 0, MODE_NONE, 32'h0, 16'h0, 26'h0, 32'h0, 32'h3004, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
Parametrised next-PC generator and PC register for the pipelined CPU; successor to the single-cycle jump-address concatenation logic.
- Owns the fetch PC.
- Forms sequential, branch, jump and register-jump targets.
- Buffers a redirect that arrives while fetch is stalled and applies it when the stall releases.
- Sits between the hazard/branch resolution logic and the instruction memory address port.

Parameters:
ADDR_W, 32, PC/address width in bits
IDX_W, 26, width of the jump instruction-index field
IMM_W, 16, width of the branch immediate, sign-extended
STEP_LOG2, 2, log2 of instruction size in bytes; also the target left-shift amount
RESET_PC, 0, PC value loaded on reset

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
stall_i  in  1  hold PC (fetch stall)
redir_valid_i  in  1  redirect request
redir_ready_o  out  1  redirect accepted this cycle when valid&ready
redir_mode_i  in  2  00 none, 01 branch, 10 jump, 11 register
redir_base_i  in  ADDR_W  PC of the control instruction
redir_imm_i  in  IMM_W  branch offset in instructions
redir_idx_i  in  IDX_W  jump index
redir_reg_i  in  ADDR_W  register-jump target
pc_o  out  ADDR_W  current fetch PC (registered)
pc_plus_o  out  ADDR_W  pc_o + 2^STEP_LOG2 (combinational)
redir_taken_o  out  1  one-cycle pulse, first cycle pc_o shows a redirect target
misalign_o  out  1  one-cycle pulse, register target misaligned (see Optional Feature)

Behaviour:
- Elaboration check: ADDR_W >= IDX_W+STEP_LOG2; violation is a fatal elaboration error.
- Reset (rst_i=0, async): pc_o=RESET_PC, state=RUN, pending buffer cleared, redir_taken_o=0, misalign_o=0.
- Reset asserted in HOLD discards the pending target.
- Target formation, all arithmetic modulo 2^ADDR_W; seq = base+2^STEP_LOG2:
  - branch = seq + (sext(imm) << STEP_LOG2).
  - jump = {seq[ADDR_W-1 : IDX_W+STEP_LOG2], idx, STEP_LOG2 zeros}; upper field empty when widths are equal.
  - register = redir_reg_i.
- States: RUN, HOLD. redir_ready_o = (state==RUN).
- RUN:
  - No accepted redirect, stall_i=0: pc_o <= pc_o + 2^STEP_LOG2, wrapping at 2^ADDR_W.
  - stall_i=1: pc_o holds.
  - Accepted redirect with mode 00: no effect; sequential rule applies.
  - Accepted redirect with mode != 00 and stall_i=0: pc_o <= target on the next edge (1-cycle latency); redir_taken_o=1 that next cycle. Redirect overrides sequential increment.
  - Accepted redirect with mode != 00 and stall_i=1: target latched into the pending buffer, -> HOLD, pc_o holds.
- HOLD:
  - redir_ready_o=0; redir_valid_i is not accepted and the requester holds it.
  - stall_i=1: remain in HOLD, pc_o holds.
  - stall_i=0: pc_o <= pending, -> RUN, redir_taken_o pulses the following cycle.
- Back-to-back redirects in RUN with no stall: each is accepted; the latest one wins every cycle.
- pc_plus_o wraps identically to the PC increment.

Optional Feature:
Macro PC_ALIGN_CHK_EN.
- Defined: a register-mode target with nonzero low STEP_LOG2 bits has those bits forced to zero before use. misalign_o pulses in the same cycle redir_taken_o pulses for that redirect.
- Undefined: the target is used unmodified and misalign_o is tied 0. The port is kept so the interface is stable.

Decomposition:
- Package pc_next_pkg:
  - redirect mode constants (MODE_NONE, MODE_BR, MODE_J, MODE_JR);
  - state encoding (ST_RUN, ST_HOLD).
- Sub-module pc_target_calc: purely combinational target formation, parameterised by ADDR_W, IDX_W, IMM_W, STEP_LOG2, including the optional alignment masking. The top level holds the FSM, PC register and pending buffer.

Test Plan:
- Reset with defaults, release, 3 free cycles -> pc_o 0x0, 0x4, 0x8, 0xC; redir_taken_o stays 0.
- Branch: base 0x100, imm 0xFFFE, stall 0 -> next cycle pc_o=0xFC, redir_taken_o=1 for exactly one cycle.
- Jump: base 0x3000_0000, idx 0x0000010 -> pc_o=0x3000_0040. Repeat with IDX_W=30 and ADDR_W=32 -> target=idx<<2.
- Stall then redirect:
  - stall_i=1, jump idx 0x40 accepted -> HOLD, redir_ready_o=0, pc_o unchanged for 4 stalled cycles.
  - Release -> pc_o=0x100 next cycle with taken pulse.
  - Reset asserted in HOLD instead -> pc_o=0, ready=1.
- Wrap: force pc_o to 0xFFFF_FFFC, no stall -> pc_o=0x0000_0000, pc_plus_o=0x4.
- Register mode, reg 0x1003:
  - with PC_ALIGN_CHK_EN -> pc_o=0x1000, misalign_o pulse;
  - without -> pc_o=0x1003, misalign_o=0.
